rs_dec_sched: RTL and testbench

Input pacer and output framer for the RS(204,188) decoder `RS_dec`.
- Accepts a byte stream from upstream on a valid/ready handshake.
- Drives the decoder's `CE`/`input_byte` pair at the mandatory minimum spacing and counts bytes into 204-byte codewords.
- Limits how many codewords are in flight inside the decoder.
- Reframes decoder output bytes (`Valid_out && CEO`) into 188-byte blocks with start/end markers and block counters.

---
 rtl/rs_dec_sched.sv | 120 ++++++++++++
 tb/tb_rs_dec_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_dec_sched.sv
// Input pacer and output framer around the RS(204,188) decoder: spaces CE pulses,
// limits codewords in flight and frames decoded bytes into 188-byte blocks.
module rs_dec_sched #(
  parameter int CE_GAP       = 8,
  parameter int IN_LEN       = 204,
  parameter int OUT_LEN      = 188,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        dec_CE,
  output logic [7:0]  dec_byte,
  input  logic [7:0]  dec_out_byte,
  input  logic        dec_CEO,
  input  logic        dec_valid_out,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sob,
  output logic        out_eob,
  output logic [15:0] blk_in_cnt,
  output logic [15:0] blk_out_cnt,
  output logic        overflow,
  output logic        busy
);

  localparam int GAP_W = $clog2(CE_GAP);
  localparam int IN_W  = $clog2(IN_LEN);
  localparam int OUT_W = $clog2(OUT_LEN);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CE_GAP - 1);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_LEN - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_LEN - 1);
  localparam logic [3:0]       INF_MAX  = 4'(MAX_INFLIGHT);

  logic [GAP_W-1:0] gap_cnt;
  logic [IN_W-1:0]  in_idx;
  logic [OUT_W-1:0] out_idx;
  logic [3:0]       inflight;
  logic             accept;
  logic             capture;
  logic             blk_start;
  logic             blk_end;

  // The limiter only blocks at a codeword boundary, so a started codeword always completes.
  assign in_ready  = !reset && (gap_cnt == '0) && !((in_idx == '0) && (inflight == INF_MAX));
  assign accept    = in_valid && in_ready;
  assign capture   = dec_valid_out && dec_CEO;
  assign blk_start = accept && (in_idx == '0);
  assign blk_end   = capture && (out_idx == OUT_LAST);
  assign busy      = (inflight != 4'd0) || (in_idx != '0);

  // Stage p0: input pacing towards the decoder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt    <= '0;
      in_idx     <= '0;
      blk_in_cnt <= '0;
      dec_CE     <= 1'b0;
      dec_byte   <= '0;
    end else begin
      dec_CE <= accept;
      if (accept) begin
        dec_byte <= in_data;
        gap_cnt  <= GAP_LOAD;
        if (in_idx == IN_LAST) begin
          in_idx     <= '0;
          blk_in_cnt <= blk_in_cnt + 16'd1;
        end else begin
          in_idx <= in_idx + 1'b1;
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Stage p1: decoder output framing, one cycle after capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_idx     <= '0;
      blk_out_cnt <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sob     <= 1'b0;
      out_eob     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= capture;
      out_sob   <= capture && (out_idx == '0);
      out_eob   <= blk_end;
      if (capture) begin
        out_data <= dec_out_byte;
        if (inflight == 4'd0) overflow <= 1'b1;
        if (blk_end) begin
          out_idx     <= '0;
          blk_out_cnt <= blk_out_cnt + 16'd1;
        end else begin
          out_idx <= out_idx + 1'b1;
        end
      end
    end
  end

  // A block is charged when it starts on input and released when its last byte leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 4'd0;
    end else begin
      case ({blk_start, blk_end})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   if (inflight != 4'd0) inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_dec_sched.sv
// Directed bench for rs_dec_sched: reset, CE pacing, upstream gaps, in-flight
// limit, output framing and overflow, checked with immediate assertions.
module tb_rs_dec_sched;

  localparam int CE_GAP = 8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        dec_CE;
  logic [7:0]  dec_byte;
  logic [7:0]  dec_out_byte;
  logic        dec_CEO;
  logic        dec_valid_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sob;
  logic        out_eob;
  logic [15:0] blk_in_cnt;
  logic [15:0] blk_out_cnt;
  logic        overflow;
  logic        busy;

  int n_cmp;
  int n_fail;
  int cyc;
  int ce_cnt;
  int last_acc;
  bit have_last;

  rs_dec_sched #(
    .CE_GAP(CE_GAP), .IN_LEN(204), .OUT_LEN(188), .MAX_INFLIGHT(2)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dec_CE(dec_CE), .dec_byte(dec_byte),
    .dec_out_byte(dec_out_byte), .dec_CEO(dec_CEO), .dec_valid_out(dec_valid_out),
    .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob), .out_eob(out_eob),
    .blk_in_cnt(blk_in_cnt), .blk_out_cnt(blk_out_cnt), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dec_CE === 1'b1) ce_cnt <= ce_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit chk_gap);
    in_valid = 1'b1;
    in_data  = b;
    for (int w = 0; w < 64 && in_ready !== 1'b1; w++) tick();
    chk("in_ready_wait", in_ready, 1);
    tick();
    chk("dec_CE_pulse", dec_CE, 1);
    chk("dec_byte", dec_byte, b);
    if (chk_gap && have_last) chk("ce_spacing", cyc - last_acc, CE_GAP);
    last_acc  = cyc;
    have_last = 1'b1;
  endtask

  task automatic capture_block(input logic [7:0] base, input bit ready_low);
    logic [7:0] v;
    for (int k = 0; k < 188; k++) begin
      v = 8'(base + k * 7);
      dec_out_byte  = v;
      dec_valid_out = 1'b1;
      dec_CEO       = 1'b1;
      tick();
      dec_CEO = 1'b0;
      chk("out_valid_hi", out_valid, 1);
      chk("out_data", out_data, v);
      chk("out_sob", out_sob, (k == 0) ? 1 : 0);
      chk("out_eob", out_eob, (k == 187) ? 1 : 0);
      if (ready_low) chk("limit_ready", in_ready, (k == 187) ? 1 : 0);
      tick();
      chk("out_valid_lo", out_valid, 0);
    end
    dec_valid_out = 1'b0;
  endtask

  initial begin
    int ce0;
    int prev_acc;
    n_cmp = 0; n_fail = 0; cyc = 0; ce_cnt = 0; last_acc = 0; have_last = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    dec_out_byte = '0; dec_CEO = 1'b0; dec_valid_out = 1'b0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_dec_CE", dec_CE, 0);
    chk("rst_dec_byte", dec_byte, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_blk_in", blk_in_cnt, 0);
    chk("rst_blk_out", blk_out_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_blk_in", blk_in_cnt, 0);

    // Pacing: one full codeword with in_valid held high
    ce0 = ce_cnt;
    for (int i = 0; i < 204; i++) send_byte(8'(i), 1'b1);
    tick();
    chk("pace_ce_count", ce_cnt - ce0, 204);
    chk("pace_blk_in", blk_in_cnt, 1);
    chk("pace_busy", busy, 1);
    chk("pace_ce_low", dec_CE, 0);

    // Upstream gap after byte 50 of the second codeword
    for (int i = 0; i < 51; i++) send_byte(8'(i), 1'b1);
    in_valid = 1'b0;
    prev_acc = last_acc;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("gap_ce_low", dec_CE, 0);
      chk("gap_byte_hold", dec_byte, 8'd50);
    end
    chk("gap_ready_back", in_ready, 1);
    send_byte(8'd51, 1'b0);
    chk("gap_resume_spacing", last_acc - prev_acc, 21);
    for (int i = 52; i < 204; i++) send_byte(8'(i), 1'b1);
    tick();
    chk("gap_blk_in", blk_in_cnt, 2);

    // In-flight limit: two codewords charged, nothing returned yet
    in_valid = 1'b1;
    in_data  = 8'hEE;
    ce0 = ce_cnt;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("limit_stall", in_ready, 0);
    end
    chk("limit_no_ce", ce_cnt - ce0, 0);
    chk("limit_blk_in", blk_in_cnt, 2);
    in_valid = 1'b0;

    // First output block releases one slot
    capture_block(8'h10, 1'b1);
    chk("blk_out_1", blk_out_cnt, 1);
    chk("ready_after_blk", in_ready, 1);
    chk("no_overflow_1", overflow, 0);

    // Second output block drains the decoder
    capture_block(8'hA3, 1'b0);
    chk("blk_out_2", blk_out_cnt, 2);
    chk("no_overflow_2", overflow, 0);
    chk("drained_busy", busy, 0);

    // Capture with nothing in flight
    dec_out_byte  = 8'h5A;
    dec_valid_out = 1'b1;
    dec_CEO       = 1'b1;
    tick();
    dec_CEO = 1'b0; dec_valid_out = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_fwd_valid", out_valid, 1);
    chk("ovf_fwd_data", out_data, 8'h5A);
    chk("ovf_fwd_sob", out_sob, 1);
    chk("ovf_no_underflow", busy, 0);
    repeat (5) tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_ready", in_ready, 1);

    // Reset mid-codeword, asserted between clock edges
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_dec_CE", dec_CE, 0);
    chk("mid_rst_dec_byte", dec_byte, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_blk_in", blk_in_cnt, 0);
    chk("mid_rst_blk_out", blk_out_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) tick();
    chk("in_rst_ce_low", dec_CE, 0);
    reset = 1'b0;
    have_last = 1'b0;
    #1;
    chk("rel2_in_ready", in_ready, 1);
    chk("rel2_blk_in", blk_in_cnt, 0);
    send_byte(8'h33, 1'b0);
    chk("rel2_busy", busy, 1);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
